// File: rtl/commit_unit_pkg.sv
// Shared rv32i types for the commit stage: ROB entry layout, ROB entry
// status encoding and the commit FSM state encoding. ROB_TAG_W is the
// width of the ROB index stored in each entry.
package commit_unit_pkg;

  localparam int ROB_TAG_W = 5;

  // Life-cycle of a ROB entry; only 'done' entries may retire.
  typedef enum logic [1:0] {
    rob_wait = 2'd0,
    done     = 2'd1,
    donex2   = 2'd2,
    empty    = 2'd3
  } rob_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } commit_state_t;

  typedef struct packed {
    logic                  valid;
    rob_status_t           status;
    logic [ROB_TAG_W-1:0]  rob_idx;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic [4:0]            rd_addr;
    logic [31:0]           rd_data;
    logic                  regf_we;
    logic                  br_en;
    logic [31:0]           pc_new;
    logic [31:0]           mem_addr;
    logic [3:0]            mem_rmask;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_rdata;
    logic [31:0]           mem_wdata;
  } rob_entry_t;

  // Architectural PC following the entry (static not-taken prediction).
  function automatic logic [31:0] next_pc(input rob_entry_t e);
    return e.br_en ? e.pc_new : (e.pc + 32'd4);
  endfunction

  // True when retiring the entry must update the regfile (x0 is hardwired).
  function automatic logic writes_rd(input rob_entry_t e);
    return e.regf_we && (e.rd_addr != 5'd0);
  endfunction

endpackage

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage sitting on the ROB head port.
// Retires at most one 'done' head entry per cycle, writes its rd to the
// regfile one cycle later, and on a taken branch/jump raises a one-cycle
// flush with a PC redirect, then blocks commit for FLUSH_CYCLES cycles
// while the ROB/RS drain.
// Optional build macro COMMIT_RVFI_EN adds registered RVFI monitor ports.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_IDX_W    = ROB_TAG_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rob_entry_t           rob_head_i,
  input  logic                 rob_empty_i,
  output logic                 rob_dequeue_o,
  output logic                 regf_we_o,
  output logic [4:0]           regf_rd_addr_o,
  output logic [31:0]          regf_rd_data_o,
  output logic [ROB_IDX_W-1:0] regf_rob_idx_o,
  output logic                 flush_o,
  output logic [31:0]          pc_redirect_o,
  output logic [63:0]          retire_cnt_o
`ifdef COMMIT_RVFI_EN
  ,
  output logic                 rvfi_valid_o,
  output logic [63:0]          rvfi_order_o,
  output logic [31:0]          rvfi_pc_rdata_o,
  output logic [31:0]          rvfi_pc_wdata_o,
  output logic [31:0]          rvfi_insn_o,
  output logic [4:0]           rvfi_rd_addr_o,
  output logic [31:0]          rvfi_rd_wdata_o,
  output logic [31:0]          rvfi_mem_addr_o,
  output logic [3:0]           rvfi_mem_rmask_o,
  output logic [3:0]           rvfi_mem_wmask_o,
  output logic [31:0]          rvfi_mem_rdata_o,
  output logic [31:0]          rvfi_mem_wdata_o
`endif
);

  // Drain counter only needs to hold FLUSH_CYCLES down to 1.
  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  commit_state_t        state_reg;
  logic [CNT_W-1:0]     drain_cnt_reg;

  logic                 regf_we_reg;
  logic [4:0]           regf_rd_addr_reg;
  logic [31:0]          regf_rd_data_reg;
  logic [ROB_IDX_W-1:0] regf_rob_idx_reg;
  logic                 flush_reg;
  logic [31:0]          pc_redirect_reg;
  logic [63:0]          retire_cnt_reg;

  logic                 can_commit;
  logic                 retire;
  logic                 mispredict;

  // Retire decision: head must be a valid, finished entry and we must be running.
  always_comb begin
    can_commit = (state_reg == RUN) && !rob_empty_i &&
                 rob_head_i.valid && (rob_head_i.status == done);
    retire     = can_commit && !rst;
    mispredict = retire && rob_head_i.br_en;
  end

  assign rob_dequeue_o = retire;

  // Commit FSM: leave IDLE after reset, park in FLUSH while the backend drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (mispredict) begin
            state_reg     <= FLUSH;
            drain_cnt_reg <= CNT_W'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          if (drain_cnt_reg <= CNT_W'(1)) begin
            state_reg     <= RUN;
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          drain_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Regfile write port: one-cycle pulse carrying the retired entry's rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      regf_we_reg      <= 1'b0;
      regf_rd_addr_reg <= '0;
      regf_rd_data_reg <= '0;
      regf_rob_idx_reg <= '0;
    end else if (retire) begin
      regf_we_reg      <= writes_rd(rob_head_i);
      regf_rd_addr_reg <= rob_head_i.rd_addr;
      regf_rd_data_reg <= rob_head_i.rd_data;
      regf_rob_idx_reg <= ROB_IDX_W'(rob_head_i.rob_idx);
    end else begin
      regf_we_reg      <= 1'b0;
      regf_rd_addr_reg <= '0;
      regf_rd_data_reg <= '0;
      regf_rob_idx_reg <= '0;
    end
  end

  // Flush pulse and redirect target; a reset drops any pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_reg       <= 1'b0;
      pc_redirect_reg <= '0;
    end else begin
      flush_reg       <= mispredict;
      pc_redirect_reg <= mispredict ? rob_head_i.pc_new : 32'd0;
    end
  end

  // Retired-instruction counter, free-running modulo 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if (retire) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end
  end

  assign regf_we_o      = regf_we_reg;
  assign regf_rd_addr_o = regf_rd_addr_reg;
  assign regf_rd_data_o = regf_rd_data_reg;
  assign regf_rob_idx_o = regf_rob_idx_reg;
  assign flush_o        = flush_reg;
  assign pc_redirect_o  = pc_redirect_reg;
  assign retire_cnt_o   = retire_cnt_reg;

`ifdef COMMIT_RVFI_EN
  logic        rvfi_valid_reg;
  logic [63:0] rvfi_order_reg;
  logic [31:0] rvfi_pc_rdata_reg;
  logic [31:0] rvfi_pc_wdata_reg;
  logic [31:0] rvfi_insn_reg;
  logic [4:0]  rvfi_rd_addr_reg;
  logic [31:0] rvfi_rd_wdata_reg;
  logic [31:0] rvfi_mem_addr_reg;
  logic [3:0]  rvfi_mem_rmask_reg;
  logic [3:0]  rvfi_mem_wmask_reg;
  logic [31:0] rvfi_mem_rdata_reg;
  logic [31:0] rvfi_mem_wdata_reg;

  // RVFI record of the retiring entry, aligned with the regfile write.
  always_ff @(posedge clk) begin
    if (rst || !retire) begin
      rvfi_valid_reg     <= 1'b0;
      rvfi_order_reg     <= '0;
      rvfi_pc_rdata_reg  <= '0;
      rvfi_pc_wdata_reg  <= '0;
      rvfi_insn_reg      <= '0;
      rvfi_rd_addr_reg   <= '0;
      rvfi_rd_wdata_reg  <= '0;
      rvfi_mem_addr_reg  <= '0;
      rvfi_mem_rmask_reg <= '0;
      rvfi_mem_wmask_reg <= '0;
      rvfi_mem_rdata_reg <= '0;
      rvfi_mem_wdata_reg <= '0;
    end else begin
      rvfi_valid_reg     <= 1'b1;
      rvfi_order_reg     <= retire_cnt_reg;
      rvfi_pc_rdata_reg  <= rob_head_i.pc;
      rvfi_pc_wdata_reg  <= next_pc(rob_head_i);
      rvfi_insn_reg      <= rob_head_i.inst;
      rvfi_rd_addr_reg   <= rob_head_i.rd_addr;
      rvfi_rd_wdata_reg  <= (rob_head_i.rd_addr == 5'd0) ? 32'd0 : rob_head_i.rd_data;
      rvfi_mem_addr_reg  <= rob_head_i.mem_addr;
      rvfi_mem_rmask_reg <= rob_head_i.mem_rmask;
      rvfi_mem_wmask_reg <= rob_head_i.mem_wmask;
      rvfi_mem_rdata_reg <= rob_head_i.mem_rdata;
      rvfi_mem_wdata_reg <= rob_head_i.mem_wdata;
    end
  end

  assign rvfi_valid_o     = rvfi_valid_reg;
  assign rvfi_order_o     = rvfi_order_reg;
  assign rvfi_pc_rdata_o  = rvfi_pc_rdata_reg;
  assign rvfi_pc_wdata_o  = rvfi_pc_wdata_reg;
  assign rvfi_insn_o      = rvfi_insn_reg;
  assign rvfi_rd_addr_o   = rvfi_rd_addr_reg;
  assign rvfi_rd_wdata_o  = rvfi_rd_wdata_reg;
  assign rvfi_mem_addr_o  = rvfi_mem_addr_reg;
  assign rvfi_mem_rmask_o = rvfi_mem_rmask_reg;
  assign rvfi_mem_wmask_o = rvfi_mem_wmask_reg;
  assign rvfi_mem_rdata_o = rvfi_mem_rdata_reg;
  assign rvfi_mem_wdata_o = rvfi_mem_wdata_reg;
`else
  // Head fields that only feed the monitor are left unconnected here.
  logic unused_monitor_fields;
  assign unused_monitor_fields = ^{rob_head_i.pc, rob_head_i.inst,
                                   rob_head_i.mem_addr, rob_head_i.mem_rmask,
                                   rob_head_i.mem_wmask, rob_head_i.mem_rdata,
                                   rob_head_i.mem_wdata};
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed steps followed by random
// head traffic, checked against a cycle-numbered reference model.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  rob_entry_t head;
  logic       rob_empty = 1'b0;

  logic        rob_dequeue_o;
  logic        regf_we_o;
  logic [4:0]  regf_rd_addr_o;
  logic [31:0] regf_rd_data_o;
  logic [4:0]  regf_rob_idx_o;
  logic        flush_o;
  logic [31:0] pc_redirect_o;
  logic [63:0] retire_cnt_o;
`ifdef COMMIT_RVFI_EN
  logic        rvfi_valid_o;
  logic [63:0] rvfi_order_o;
  logic [31:0] rvfi_pc_rdata_o, rvfi_pc_wdata_o, rvfi_insn_o, rvfi_rd_wdata_o;
  logic [4:0]  rvfi_rd_addr_o;
  logic [31:0] rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [3:0]  rvfi_mem_rmask_o, rvfi_mem_wmask_o;
`endif

  commit_unit #(.ROB_IDX_W(5), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .rob_head_i     (head),
    .rob_empty_i    (rob_empty),
    .rob_dequeue_o  (rob_dequeue_o),
    .regf_we_o      (regf_we_o),
    .regf_rd_addr_o (regf_rd_addr_o),
    .regf_rd_data_o (regf_rd_data_o),
    .regf_rob_idx_o (regf_rob_idx_o),
    .flush_o        (flush_o),
    .pc_redirect_o  (pc_redirect_o),
    .retire_cnt_o   (retire_cnt_o)
`ifdef COMMIT_RVFI_EN
    ,
    .rvfi_valid_o     (rvfi_valid_o),
    .rvfi_order_o     (rvfi_order_o),
    .rvfi_pc_rdata_o  (rvfi_pc_rdata_o),
    .rvfi_pc_wdata_o  (rvfi_pc_wdata_o),
    .rvfi_insn_o      (rvfi_insn_o),
    .rvfi_rd_addr_o   (rvfi_rd_addr_o),
    .rvfi_rd_wdata_o  (rvfi_rd_wdata_o),
    .rvfi_mem_addr_o  (rvfi_mem_addr_o),
    .rvfi_mem_rmask_o (rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o (rvfi_mem_wmask_o),
    .rvfi_mem_rdata_o (rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o (rvfi_mem_wdata_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: retirement allowed from clock edge number allow_edge on.
  int          edge_num   = 0;
  int          allow_edge = 1000000;
  logic        exp_we = 1'b0, exp_flush = 1'b0;
  logic [4:0]  exp_addr = '0, exp_idx = '0;
  logic [31:0] exp_data = '0, exp_redirect = '0;
  logic [63:0] exp_cnt = '0;
  logic        exp_rv_valid = 1'b0;
  logic [63:0] exp_rv_order = '0;
  logic [31:0] exp_rv_pc = '0, exp_rv_pcw = '0, exp_rv_insn = '0, exp_rv_wdata = '0, exp_rv_maddr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rob_entry_t make_entry(input logic valid, input rob_status_t st,
                                            input logic [4:0] rd, input logic [31:0] data,
                                            input logic we, input logic br,
                                            input logic [31:0] pc, input logic [31:0] pc_new);
    rob_entry_t e;
    e.valid     = valid;
    e.status    = st;
    e.rob_idx   = 5'($urandom_range(0, 31));
    e.pc        = pc;
    e.inst      = $urandom;
    e.rd_addr   = rd;
    e.rd_data   = data;
    e.regf_we   = we;
    e.br_en     = br;
    e.pc_new    = pc_new;
    e.mem_addr  = $urandom;
    e.mem_rmask = 4'($urandom_range(0, 15));
    e.mem_wmask = 4'($urandom_range(0, 15));
    e.mem_rdata = $urandom;
    e.mem_wdata = $urandom;
    return e;
  endfunction

  // One clock: check dequeue before the edge, advance model, check outputs after.
  task automatic step(input string name);
    logic deq_exp;
    @(negedge clk);
    deq_exp = !rst && (edge_num + 1 >= allow_edge) && !rob_empty &&
              head.valid && (head.status == done);
    check({name, ":dequeue"}, {63'd0, rob_dequeue_o}, {63'd0, deq_exp});
    @(posedge clk);
    edge_num++;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_idx = '0;
    exp_flush = 1'b0; exp_redirect = '0;
    exp_rv_valid = 1'b0; exp_rv_order = '0; exp_rv_pc = '0; exp_rv_pcw = '0;
    exp_rv_insn = '0; exp_rv_wdata = '0; exp_rv_maddr = '0;
    if (rst) begin
      exp_cnt    = '0;
      allow_edge = edge_num + 2;
    end else if (deq_exp) begin
      exp_we       = head.regf_we && (head.rd_addr != 0);
      exp_addr     = head.rd_addr;
      exp_data     = head.rd_data;
      exp_idx      = head.rob_idx;
      exp_rv_valid = 1'b1;
      exp_rv_order = exp_cnt;
      exp_rv_pc    = head.pc;
      exp_rv_pcw   = head.br_en ? head.pc_new : head.pc + 4;
      exp_rv_insn  = head.inst;
      exp_rv_wdata = (head.rd_addr == 0) ? 32'd0 : head.rd_data;
      exp_rv_maddr = head.mem_addr;
      if (head.br_en) begin
        exp_flush    = 1'b1;
        exp_redirect = head.pc_new;
        allow_edge   = edge_num + FLUSH_CYCLES + 1;
      end
      exp_cnt = exp_cnt + 1;
    end
    #1;
    check({name, ":regf_we"},   {63'd0, regf_we_o},      {63'd0, exp_we});
    check({name, ":rd_addr"},   {59'd0, regf_rd_addr_o}, {59'd0, exp_addr});
    check({name, ":rd_data"},   {32'd0, regf_rd_data_o}, {32'd0, exp_data});
    check({name, ":rob_idx"},   {59'd0, regf_rob_idx_o}, {59'd0, exp_idx});
    check({name, ":flush"},     {63'd0, flush_o},        {63'd0, exp_flush});
    check({name, ":redirect"},  {32'd0, pc_redirect_o},  {32'd0, exp_redirect});
    check({name, ":retire_cnt"}, retire_cnt_o, exp_cnt);
`ifdef COMMIT_RVFI_EN
    check({name, ":rvfi_valid"}, {63'd0, rvfi_valid_o},   {63'd0, exp_rv_valid});
    check({name, ":rvfi_order"}, rvfi_order_o,            exp_rv_order);
    check({name, ":rvfi_pc"},    {32'd0, rvfi_pc_rdata_o}, {32'd0, exp_rv_pc});
    check({name, ":rvfi_pcw"},   {32'd0, rvfi_pc_wdata_o}, {32'd0, exp_rv_pcw});
    check({name, ":rvfi_insn"},  {32'd0, rvfi_insn_o},     {32'd0, exp_rv_insn});
    check({name, ":rvfi_rd"},    {59'd0, rvfi_rd_addr_o},  {59'd0, exp_addr});
    check({name, ":rvfi_wdata"}, {32'd0, rvfi_rd_wdata_o}, {32'd0, exp_rv_wdata});
    check({name, ":rvfi_maddr"}, {32'd0, rvfi_mem_addr_o}, {32'd0, exp_rv_maddr});
`endif
    $display("[%0t] %s rst=%0b deq=%0b we=%0b rd=%0d data=%08h flush=%0b redir=%08h cnt=%0d",
             $time, name, rst, rob_dequeue_o, regf_we_o, regf_rd_addr_o, regf_rd_data_o,
             flush_o, pc_redirect_o, retire_cnt_o);
  endtask

  initial begin
    // Reset held three cycles with a done entry waiting at the head.
    rst  = 1'b1;
    head = make_entry(1'b1, done, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) step("reset");
    check("reset:retire_cnt_zero", retire_cnt_o, 64'd0);

    // First cycle out of reset is the IDLE -> RUN transition.
    rst = 1'b0;
    step("idle");

    // ADDI x5 retires immediately.
    head = make_entry(1'b1, done, 5'd5, 32'h11, 1'b1, 1'b0, 32'h200, 32'h0);
    step("addi_x5");
    check("addi_x5:we_const",   {63'd0, regf_we_o}, 64'd1);
    check("addi_x5:data_const", {32'd0, regf_rd_data_o}, 64'h11);
    check("addi_x5:cnt_const",  retire_cnt_o, 64'd1);

    // Write to x0 is suppressed but still retires.
    head = make_entry(1'b1, done, 5'd0, 32'h55, 1'b1, 1'b0, 32'h204, 32'h0);
    step("x0_write");
    check("x0_write:we_const", {63'd0, regf_we_o}, 64'd0);

    // Taken BEQ: flush next cycle, then two blocked cycles with a done head.
    head = make_entry(1'b1, done, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h1040);
    step("beq_taken");
    check("beq_taken:redirect_const", {32'd0, pc_redirect_o}, 64'h1040);
    head = make_entry(1'b1, done, 5'd9, 32'h99, 1'b1, 1'b0, 32'h1040, 32'h0);
    step("drain1");
    step("drain2");
    step("resume");

    // Three back-to-back done entries, then a waiting head stalls.
    for (int i = 0; i < 3; i++) begin
      head = make_entry(1'b1, done, 5'(10 + i), 32'(32'hA0 + i), 1'b1, 1'b0, 32'(32'h300 + 4 * i), 32'h0);
      step("burst");
    end
    head = make_entry(1'b1, rob_wait, 5'd3, 32'h33, 1'b1, 1'b0, 32'h30C, 32'h0);
    step("stall_wait");
    head.status = donex2;
    step("stall_donex2");
    head.status = done;
    head.valid  = 1'b0;
    step("stall_invalid");
    head.valid = 1'b1;
    rob_empty  = 1'b1;
    step("stall_empty");
    rob_empty = 1'b0;

    // JAL retires, reset lands during FLUSH, then retirement resumes.
    head = make_entry(1'b1, done, 5'd1, 32'h404, 1'b1, 1'b1, 32'h400, 32'h800);
    step("jal");
    rst = 1'b1;
    step("rst_in_flush");
    check("rst_in_flush:flush_const", {63'd0, flush_o}, 64'd0);
    rst  = 1'b0;
    head = make_entry(1'b1, done, 5'd2, 32'h22, 1'b1, 1'b0, 32'h800, 32'h0);
    step("post_rst_idle");
    step("post_rst_retire");

    // Random traffic including occasional mispredicts, stalls and resets.
    for (int i = 0; i < 400; i++) begin
      head = make_entry(1'b1, done, 5'($urandom_range(0, 31)), $urandom,
                        1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                        $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) == 0) head.status = rob_status_t'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) head.valid = 1'b0;
      rob_empty = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
